// File: rtl/led_status_pkg.sv
// led_status_pkg: shared types and constants for the status-LED scheduler
package led_status_pkg;
    localparam int PAT_W = 3;
    typedef enum logic [PAT_W-1:0] {
        PAT_OFF,
        PAT_ON,
        PAT_SLOW,
        PAT_FAST,
        PAT_HEART,
        PAT_BREATHE
    } pattern_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } sched_state_e;
endpackage

// File: rtl/led_status_sched_if.sv
// led_status_sched_if: requester inputs and grant/LED outputs of the status-LED scheduler
interface led_status_sched_if
    import led_status_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       urgent;
    logic [PAT_W*N_REQ-1:0] pattern;
    logic [N_REQ-1:0]       grant;
    logic [IW-1:0]          active_id;
    logic                   busy;
    logic                   pwm;
    modport master (output req, urgent, pattern, input grant, active_id, busy, pwm);
    modport slave (input req, urgent, pattern, output grant, active_id, busy, pwm);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: blink/heartbeat waveform for the latched pattern code; breathe (code 5) exists only when LED_STATUS_SCHED_BREATHE_EN is defined
module led_pattern_gen
    import led_status_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int PWM_BITS  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic [PAT_W-1:0] code_i,
    output logic             pwm_o
);
    localparam int HEART_P = 4 * BLINK_DIV;
    localparam int FAST_H  = (BLINK_DIV >= 4) ? BLINK_DIV / 4 : 1;
    localparam int PULSE   = (BLINK_DIV >= 8) ? BLINK_DIV / 8 : 1;
    localparam int HW      = $clog2(HEART_P);
    localparam int SW      = $clog2(2 * BLINK_DIV);
    localparam int FW      = $clog2(2 * FAST_H);

    logic [PAT_W-1:0] code_q, code_d;
    logic [HW-1:0]    heart_q, heart_d;
    logic [SW-1:0]    slow_q, slow_d;
    logic [FW-1:0]    fast_q, fast_d;
    logic             slow_on, fast_on, heart_on, breathe_on;

    // Phase counters wrap on their own period and restart from zero on every grant
    always_comb begin
        code_d  = restart_i ? code_i : code_q;
        heart_d = (restart_i || heart_q == HW'(HEART_P - 1)) ? '0 : heart_q + 1'b1;
        slow_d  = (restart_i || slow_q == SW'(2 * BLINK_DIV - 1)) ? '0 : slow_q + 1'b1;
        fast_d  = (restart_i || fast_q == FW'(2 * FAST_H - 1)) ? '0 : fast_q + 1'b1;
    end

    // Pattern code and phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            heart_q <= '0;
            slow_q  <= '0;
            fast_q  <= '0;
        end else begin
            code_q  <= code_d;
            heart_q <= heart_d;
            slow_q  <= slow_d;
            fast_q  <= fast_d;
        end
    end

    assign slow_on  = slow_q < SW'(BLINK_DIV);
    assign fast_on  = fast_q < FW'(FAST_H);
    assign heart_on = (heart_q < HW'(PULSE)) || (heart_q >= HW'(2 * PULSE) && heart_q < HW'(3 * PULSE));

`ifdef LED_STATUS_SCHED_BREATHE_EN
    localparam int STEP = (((2 * BLINK_DIV) >> PWM_BITS) > 1) ? ((2 * BLINK_DIV) >> PWM_BITS) : 1;
    localparam int DW   = (STEP > 1) ? $clog2(STEP) : 1;

    logic [DW-1:0]       div_q, div_d;
    logic [PWM_BITS-1:0] duty_q, duty_d, carrier_q, carrier_d;
    logic                down_q, down_d;
    logic                step;

    assign step = div_q == DW'(STEP - 1);

    // Triangle duty ramp, one duty step every STEP cycles, holding one step at each end
    always_comb begin
        div_d     = (restart_i || step) ? '0 : div_q + 1'b1;
        carrier_d = restart_i ? '0 : carrier_q + 1'b1;
        duty_d    = duty_q;
        down_d    = down_q;
        if (restart_i) begin
            duty_d = '0;
            down_d = 1'b0;
        end else if (step && !down_q) begin
            down_d = &duty_q;
            duty_d = (&duty_q) ? duty_q : duty_q + 1'b1;
        end else if (step) begin
            down_d = duty_q != '0;
            duty_d = (duty_q == '0) ? duty_q : duty_q - 1'b1;
        end
    end

    // Breathe ramp registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            duty_q    <= '0;
            carrier_q <= '0;
            down_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            duty_q    <= duty_d;
            carrier_q <= carrier_d;
            down_q    <= down_d;
        end
    end

    assign breathe_on = carrier_q < duty_q;
`else
    assign breathe_on = slow_on;
`endif

    // Waveform select; off and the unused codes 6/7 stay dark
    always_comb begin
        pwm_o = 1'b0;
        case (code_q)
            PAT_ON:      pwm_o = 1'b1;
            PAT_SLOW:    pwm_o = slow_on;
            PAT_FAST:    pwm_o = fast_on;
            PAT_HEART:   pwm_o = heart_on;
            PAT_BREATHE: pwm_o = breathe_on;
            default:     pwm_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/led_status_sched.sv
// led_status_sched: shares one status LED among N_REQ requesters (urgent first, then round-robin), with a dark gap between owners; LED_STATUS_SCHED_BREATHE_EN enables the breathe pattern
module led_status_sched
    import led_status_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SLOT_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 20_000_000,
    parameter int BLINK_DIV   = 25_000_000,
    parameter int PWM_BITS    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    led_status_sched_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    sched_state_e     state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d, rr_q, rr_d, win_id;
    logic [SW-1:0]    slot_q, slot_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [N_REQ-1:0] own_oh;
    logic [PAT_W-1:0] code_sel;
    logic             win_urg, take, restart, preempt, others, gen_pwm;
    int               j;

    assign own_oh  = {{(N_REQ - 1){1'b0}}, 1'b1} << owner_q;
    assign preempt = (|(bus.urgent & bus.req & ~own_oh)) && !(bus.urgent[owner_q] && bus.req[owner_q]);
    assign others  = |(bus.req & ~own_oh);

    // Winner: lowest urgent requester, otherwise the first requester after rr_q going round
    always_comb begin
        win_id  = '0;
        win_urg = 1'b0;
        j       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = int'(rr_q) + k;
            j = (j >= N_REQ) ? j - N_REQ : j;
            if (bus.req[IW'(j)]) win_id = IW'(j);
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.urgent[IW'(k)] && bus.req[IW'(k)]) begin
                win_id  = IW'(k);
                win_urg = 1'b1;
            end
        end
    end

    // Next state: slot and gap timing, preemption, handover and same-owner slot restart
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        slot_d   = slot_q;
        gap_d    = gap_q;
        take     = 1'b0;
        restart  = 1'b0;
        code_sel = bus.pattern[PAT_W*int'(owner_q) +: PAT_W];
        case (state_q)
            S_IDLE: take = |bus.req;
            S_SHOW: begin
                if (!bus.req[owner_q] || preempt || (slot_q == SLOT_LAST && others)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else if (slot_q == SLOT_LAST) begin
                    slot_d  = '0;
                    restart = 1'b1;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q != GAP_LAST) gap_d = gap_q + 1'b1;
                else if (|bus.req) take = 1'b1;
                else state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            state_d  = S_SHOW;
            owner_d  = win_id;
            slot_d   = '0;
            restart  = 1'b1;
            code_sel = bus.pattern[PAT_W*int'(win_id) +: PAT_W];
            rr_d     = win_urg ? rr_q : win_id;
        end
    end

    // State, owner, round-robin pointer and counters; async reset darkens the LED at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= IW'(N_REQ - 1);
            slot_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            slot_q  <= slot_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.grant     = (state_q == S_SHOW) ? own_oh : '0;
    assign bus.active_id = owner_q;
    assign bus.busy      = state_q != S_IDLE;
    assign bus.pwm       = (state_q == S_SHOW) && gen_pwm;

    led_pattern_gen #(
        .BLINK_DIV (BLINK_DIV),
        .PWM_BITS  (PWM_BITS)
    ) u_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .code_i    (code_sel),
        .pwm_o     (gen_pwm)
    );
endmodule

// File: tb/tb_led_status_sched.sv
// tb_led_status_sched: table-driven scoreboard bench for led_status_sched (N_REQ=4, SLOT=20, GAP=4, BLINK_DIV=8, PWM_BITS=4)
module tb_led_status_sched;
    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       pwm;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  urg;
        logic [11:0] pat;
        int          cycles;
        exp_t        e;
        string       name;
    } vec_t;

    localparam logic [11:0] PA = {3'bxxx, 3'b000, 3'b001, 3'bxxx};
    localparam logic [11:0] PB = {3'b000, 3'b000, 3'b001, 3'bxxx};

    logic clk, rst_n;
    int   n_cmp, n_err;
    exp_t sb_q[$];
    vec_t vecs[$];
    int   codes[7];
    int   nxt;

    led_status_sched_if #(.N_REQ(4)) bus ();

    led_status_sched #(
        .N_REQ       (4),
        .SLOT_CYCLES (20),
        .GAP_CYCLES  (4),
        .BLINK_DIV   (8),
        .PWM_BITS    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pat_model(input int code, input int t);
        case (code)
            1: return 1'b1;
            2: return (t % 16) < 8;
            3: return (t % 4) < 2;
            4: return t == 0 || t == 2;
`ifdef LED_STATUS_SCHED_BREATHE_EN
            5: return (t % 16) < ((t < 16) ? t : 31 - t);
`else
            5: return (t % 16) < 8;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] u, input logic [11:0] p, input int n,
                                input logic [3:0] g, input logic [1:0] i, input logic b, input logic w, input string s);
        vec_t v;
        v.req    = r;
        v.urg    = u;
        v.pat    = p;
        v.cycles = n;
        v.e      = '{grant: g, id: i, busy: b, pwm: w};
        v.name   = s;
        return v;
    endfunction

    task automatic check(input string name);
        exp_t e, a;
        e = sb_q.pop_front();
        a = '{grant: bus.grant, id: bus.active_id, busy: bus.busy, pwm: bus.pwm};
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b pwm=%b, want grant=%b id=%0d busy=%b pwm=%b",
                     name, a.grant, a.id, a.busy, a.pwm, e.grant, e.id, e.busy, e.pwm);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] u, input logic [11:0] p, input exp_t e, input string name);
        bus.req     = r;
        bus.urgent  = u;
        bus.pattern = p;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.urgent  = '0;
        bus.pattern = '0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back('{grant: 4'b0000, id: 2'd0, busy: 1'b0, pwm: 1'b0});
        check("in_reset");
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs.push_back(mk(4'b0000, 4'b0000, PA, 3, 4'b0000, 2'd0, 1'b0, 1'b0, "idle"));
        vecs.push_back(mk(4'b0110, 4'b0000, PA, 20, 4'b0010, 2'd1, 1'b1, 1'b1, "rr_req1"));
        vecs.push_back(mk(4'b0110, 4'b0000, PA, 4, 4'b0000, 2'd1, 1'b1, 1'b0, "gap1"));
        vecs.push_back(mk(4'b0110, 4'b0000, PA, 20, 4'b0100, 2'd2, 1'b1, 1'b0, "rr_req2"));
        vecs.push_back(mk(4'b0110, 4'b0000, PA, 4, 4'b0000, 2'd2, 1'b1, 1'b0, "gap2"));
        vecs.push_back(mk(4'b0110, 4'b0000, PA, 20, 4'b0010, 2'd1, 1'b1, 1'b1, "rr_back1"));
        vecs.push_back(mk(4'b0000, 4'b0000, PA, 4, 4'b0000, 2'd1, 1'b1, 1'b0, "drop_gap"));
        vecs.push_back(mk(4'b0000, 4'b0000, PA, 3, 4'b0000, 2'd1, 1'b0, 1'b0, "idle_again"));
        vecs.push_back(mk(4'b0010, 4'b0000, PB, 5, 4'b0010, 2'd1, 1'b1, 1'b1, "req1"));
        vecs.push_back(mk(4'b1010, 4'b1000, PB, 4, 4'b0000, 2'd1, 1'b1, 1'b0, "preempt_gap"));
        vecs.push_back(mk(4'b1010, 4'b1000, PB, 10, 4'b1000, 2'd3, 1'b1, 1'b0, "urgent3"));
        vecs.push_back(mk(4'b0010, 4'b0000, PB, 4, 4'b0000, 2'd3, 1'b1, 1'b0, "drop3_gap"));
        vecs.push_back(mk(4'b0010, 4'b0000, PB, 5, 4'b0010, 2'd1, 1'b1, 1'b1, "regrant1"));
        codes = '{2, 4, 3, 7, 5, 6, 1};

        do_reset();
        foreach (vecs[i])
            for (int c = 0; c < vecs[i].cycles; c++)
                step(vecs[i].req, vecs[i].urg, vecs[i].pat, vecs[i].e, $sformatf("%s[%0d]", vecs[i].name, c));

        // back-to-back slots of one owner; pattern edits land mid-slot and must wait for the next slot
        do_reset();
        for (int s = 0; s < 7; s++) begin
            for (int t = 0; t < 20; t++) begin
                nxt = (t >= 10 && s < 6) ? codes[s + 1] : codes[s];
                step(4'b0001, 4'b0000, {9'bxxxxxxxxx, 3'(nxt)},
                     '{grant: 4'b0001, id: 2'd0, busy: 1'b1, pwm: pat_model(codes[s], t)},
                     $sformatf("pat%0d_t%0d", codes[s], t));
            end
        end

        // asynchronous reset in the middle of a lit slot
        rst_n = 1'b0;
        #2;
        sb_q.push_back('{grant: 4'b0000, id: 2'd0, busy: 1'b0, pwm: 1'b0});
        check("async_rst");
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back('{grant: 4'b0000, id: 2'd0, busy: 1'b0, pwm: 1'b0});
        check("rst_hold");
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++)
            step(4'b1001, 4'b0000, {3'bxxx, 6'b000000, 3'd1},
                 '{grant: 4'b0001, id: 2'd0, busy: 1'b1, pwm: 1'b1}, $sformatf("post_rst_req0_first[%0d]", c));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
